adder_sum_decomposer: RTL

//   Inverse of the registered 8-bit adder: recovers the second operand from a 9-bit sum and the first operand (in2 = sum - in1).

---
 rtl/adder_sum_decomposer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/adder_sum_decomposer.sv
// -----------------------------------------------------------------------------
// adder_sum_decomposer
//   Recovers the second operand of a registered WIDTH-bit adder from its
//   (WIDTH+1)-bit sum and first operand: op2 = sum - op1. Input beats arrive
//   over a valid/ready handshake. Each result is queued in a DEPTH-entry FIFO
//   together with a range-error flag. The flag is set when no op2 in
//   0..2^WIDTH-1 could have produced the given sum. A saturating counter
//   records how many accepted beats carried a range error.
//
// Ports
//   clk        in   1         clock, all state updates on the rising edge
//   reset      in   1         asynchronous, active-high reset
//   in_valid   in   1         input beat present
//   in_ready   out  1         block can accept a beat this cycle
//   in_sum     in   WIDTH+1   sum as produced by the adder
//   in_op1     in   WIDTH     first operand of that sum
//   out_valid  out  1         FIFO head holds a result
//   out_ready  in   1         downstream consumes the head this cycle
//   out_op2    out  WIDTH     recovered operand at the FIFO head (0 when empty)
//   out_err    out  1         range error flag at the FIFO head (0 when empty)
//   err_count  out  CNT_W     saturating count of accepted errored beats
// -----------------------------------------------------------------------------
module adder_sum_decomposer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_op1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_op2,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Each FIFO entry is {err, op2}.
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_err_count;

    logic [WIDTH+1:0] w_diff;
    logic             w_err;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_head;

    // The subtraction is two bits wider than the operand.
    // Bit WIDTH+1 is the borrow, meaning sum < op1.
    // Bit WIDTH means the difference is at least 2^WIDTH.
    // Either bit means no valid op2 exists for this pair.
    assign w_diff = {1'b0, in_sum} - {2'b0, in_op1};
    assign w_err  = w_diff[WIDTH+1] | w_diff[WIDTH];

    // Handshake flags depend only on registered occupancy.
    // This keeps in_ready free of any path from out_ready.
    // As a result, a full FIFO refuses a push even in a cycle where it pops.
    assign in_ready  = (r_occ != OCC_FULL);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_op2   = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_err   = out_valid ? w_head[WIDTH]     : 1'b0;
    assign err_count = r_err_count;

    // Storage: only the entry under the write pointer is written.
    // Errored beats are stored with their wrapped low bits, not clamped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {w_err, w_diff[WIDTH-1:0]};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // Occupancy is tracked separately, so full and empty are unambiguous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The error count is taken at accept time and sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_push && w_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

endmodule
